// File: rtl/regfile_ctrl_fsm.sv
// Instruction decoder and Moore control FSM for the register-file datapath.
// Latches a 16-bit instruction in WAIT and, on start, steps through the read,
// ALU and write-back states. Each state lasts one clock.
module regfile_ctrl_fsm #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RN_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    input  logic              load,
    input  logic              s,
    output logic              w,
    output logic [RN_W-1:0]   readnum,
    output logic [RN_W-1:0]   writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              vsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [DATA_W-1:0] sximm8,
    output logic              illegal
);

    typedef enum logic [2:0] {
        StWait,
        StDecode,
        StGetA,
        StGetB,
        StAlu,
        StWrReg,
        StWrImm
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q;

    // Instruction fields
    logic [2:0]      opc;
    logic [1:0]      op;
    logic [RN_W-1:0] rn, rd, rm;
    logic [1:0]      sh;

    assign opc = ir_q[15:13];
    assign op  = ir_q[12:11];
    assign rn  = ir_q[10:8];
    assign rd  = ir_q[7:5];
    assign sh  = ir_q[4:3];
    assign rm  = ir_q[2:0];

    assign sximm8 = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};

    // Opcode classes
    logic is_mov_imm, is_mov_reg, is_mvn, is_alu2, is_cmp;

    assign is_mov_imm = (opc == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opc == 3'b110) && (op == 2'b00);
    assign is_mvn     = (opc == 3'b101) && (op == 2'b11);
    assign is_alu2    = (opc == 3'b101) && (op != 2'b11);
    assign is_cmp     = (opc == 3'b101) && (op == 2'b01);

    // State and instruction register; IR only accepts a new word while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StWait;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == StWait) && load) begin
                ir_q <= in;
            end
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d  = state_q;
        w        = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        vsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        illegal  = 1'b0;
        unique case (state_q)
            StWait: begin
                w = 1'b1;
                if (s) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_mov_imm) begin
                    state_d = StWrImm;
                end else if (is_mov_reg || is_mvn) begin
                    state_d = StGetB;
                end else if (is_alu2) begin
                    state_d = StGetA;
                end else begin
                    illegal = 1'b1;
                    state_d = StWait;
                end
            end
            StGetA: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = StGetB;
            end
            StGetB: begin
                readnum = rm;
                loadb   = 1'b1;
                shift   = sh;
                state_d = StAlu;
            end
            StAlu: begin
                shift = sh;
                // MOV reg passes B through an ADD with A forced to zero
                ALUop = is_mov_reg ? 2'b00 : op;
                asel  = is_mov_reg || is_mvn;
                if (is_cmp) begin
                    loads   = 1'b1;
                    state_d = StWait;
                end else begin
                    loadc   = 1'b1;
                    state_d = StWrReg;
                end
            end
            StWrReg: begin
                writenum = rd;
                write    = 1'b1;
                state_d  = StWait;
            end
            StWrImm: begin
                writenum = rn;
                vsel     = 1'b1;
                write    = 1'b1;
                state_d  = StWait;
            end
            default: state_d = StWait;
        endcase
    end

endmodule
